// File: rtl/encoder_8to3.sv
// Clocked priority encoder: reduces a request vector to the index of the winning
// set bit plus a valid flag, with one cycle of registered latency.
// Optional feature macro: ENCODER_ONEHOT_CHECK_EN adds a registered onehot_err
// output that flags samples with two or more request bits set.
module encoder_8to3 #(
    parameter int unsigned IN_W         = 8,
    parameter int unsigned OUT_W        = 3,
    parameter int unsigned LSB_PRIORITY = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    output logic [OUT_W-1:0] out,
`ifdef ENCODER_ONEHOT_CHECK_EN
    output logic             onehot_err,
`endif
    output logic             valid
);

    // Reject inconsistent width/priority configurations at elaboration.
    generate
        if (IN_W < 2 || (IN_W & (IN_W - 1)) != 0) begin : g_bad_in_w
            $error("encoder_8to3: IN_W must be a power of 2 and at least 2");
        end
        if (OUT_W != $clog2(IN_W)) begin : g_bad_out_w
            $error("encoder_8to3: OUT_W must equal log2(IN_W)");
        end
        if (LSB_PRIORITY > 1) begin : g_bad_prio
            $error("encoder_8to3: LSB_PRIORITY must be 0 or 1");
        end
    endgenerate

    logic [OUT_W-1:0] out_d,   out_q;
    logic             valid_d, valid_q;

    // Priority search: the last matching bit visited in scan order wins.
    always_comb begin
        out_d   = '0;
        valid_d = |in;
        if (LSB_PRIORITY == 0) begin
            for (int i = 0; i < int'(IN_W); i++) begin
                if (in[i]) out_d = OUT_W'(i);
            end
        end else begin
            for (int i = int'(IN_W) - 1; i >= 0; i--) begin
                if (in[i]) out_d = OUT_W'(i);
            end
        end
    end

    // Output registers with synchronous reset overriding the sampled request.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;

`ifdef ENCODER_ONEHOT_CHECK_EN
    logic onehot_err_d, onehot_err_q;

    // Clearing the lowest set bit leaves something only when 2+ bits were set.
    always_comb begin
        onehot_err_d = 1'b0;
        onehot_err_d = |(in & (in - IN_W'(1)));
    end

    // Error flag register, aligned with out/valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            onehot_err_q <= 1'b0;
        end else begin
            onehot_err_q <= onehot_err_d;
        end
    end

    assign onehot_err = onehot_err_q;
`endif

endmodule

// File: tb/tb_encoder_8to3.sv
// Directed bench for encoder_8to3: MSB- and LSB-priority instances share the stimulus.
// Build with ENCODER_ONEHOT_CHECK_EN defined to also check onehot_err.
module tb_encoder_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] in_s;
    logic [2:0] out_msb, out_lsb;
    logic       valid_msb, valid_lsb;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic       err_msb, err_lsb;
`endif

    int checks;
    int errors;

    encoder_8to3 #(.IN_W(8), .OUT_W(3), .LSB_PRIORITY(0)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .in         (in_s),
        .out        (out_msb),
`ifdef ENCODER_ONEHOT_CHECK_EN
        .onehot_err (err_msb),
`endif
        .valid      (valid_msb)
    );

    encoder_8to3 #(.IN_W(8), .OUT_W(3), .LSB_PRIORITY(1)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .in         (in_s),
        .out        (out_lsb),
`ifdef ENCODER_ONEHOT_CHECK_EN
        .onehot_err (err_lsb),
`endif
        .valid      (valid_lsb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: highest set bit index, 0 when empty.
    function automatic logic [31:0] ref_msb(input logic [7:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 7; k >= 0; k--) begin
            if (v[k]) begin
                r = 32'(k);
                break;
            end
        end
        return r;
    endfunction

    // Reference: lowest set bit index, 0 when empty.
    function automatic logic [31:0] ref_lsb(input logic [7:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) begin
                r = 32'(k);
                break;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_multi(input logic [7:0] v);
        int n;
        n = 0;
        for (int k = 0; k < 8; k++) n += int'(v[k]);
        return (n >= 2) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one sample across a rising edge and settle before checking.
    task automatic step(input logic [7:0] v, input logic r);
        in_s = v;
        rst  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_both(input string tag, input logic [31:0] e_msb, input logic [31:0] e_lsb,
                              input logic [31:0] e_valid, input logic [31:0] e_err);
        check({tag, " msb.out"},   32'(out_msb),   e_msb);
        check({tag, " msb.valid"}, 32'(valid_msb), e_valid);
        check({tag, " lsb.out"},   32'(out_lsb),   e_lsb);
        check({tag, " lsb.valid"}, 32'(valid_lsb), e_valid);
`ifdef ENCODER_ONEHOT_CHECK_EN
        check({tag, " msb.err"},   32'(err_msb),   e_err);
        check({tag, " lsb.err"},   32'(err_lsb),   e_err);
`else
        if (e_err > 32'd1) $display("note: unexpected err expectation");
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        in_s   = 8'hFF;
        @(negedge clk);

        // Reset held 3 cycles with all requests set.
        for (int c = 0; c < 3; c++) begin
            step(8'hFF, 1'b1);
            check_both("reset_hold", 32'd0, 32'd0, 32'd0, 32'd0);
        end
        step(8'hFF, 1'b0);
        check_both("reset_release", 32'd7, 32'd0, 32'd1, 32'd1);

        // Exhaustive sweep of every request pattern.
        for (int v = 0; v < 256; v++) begin
            logic [7:0] vv;
            vv = 8'(v);
            step(vv, 1'b0);
            check_both($sformatf("sweep_%02h", vv), ref_msb(vv), ref_lsb(vv),
                       (vv != 8'h00) ? 32'd1 : 32'd0, ref_multi(vv));
        end

        // Hand-computed spot values.
        step(8'h30, 1'b0);
        check_both("in_30", 32'd5, 32'd4, 32'd1, 32'd1);
        step(8'h50, 1'b0);
        check_both("in_50", 32'd6, 32'd4, 32'd1, 32'd1);
        step(8'hFF, 1'b0);
        check_both("in_ff", 32'd7, 32'd0, 32'd1, 32'd1);

        // One-hot walk: both priorities agree.
        for (int k = 0; k < 8; k++) begin
            step(8'(1 << k), 1'b0);
            check_both($sformatf("onehot_%0d", k), 32'(k), 32'(k), 32'd1, 32'd0);
        end

        // Back-to-back changes.
        step(8'h01, 1'b0);
        check_both("b2b_01", 32'd0, 32'd0, 32'd1, 32'd0);
        step(8'h80, 1'b0);
        check_both("b2b_80", 32'd7, 32'd7, 32'd1, 32'd0);
        step(8'h00, 1'b0);
        check_both("b2b_00", 32'd0, 32'd0, 32'd0, 32'd0);

        // Hold: unchanged input keeps the output.
        step(8'h50, 1'b0);
        step(8'h50, 1'b0);
        check_both("hold_50", 32'd6, 32'd4, 32'd1, 32'd1);

        // Mid-stream reset during 0x80.
        step(8'h01, 1'b0);
        check_both("mid_01", 32'd0, 32'd0, 32'd1, 32'd0);
        step(8'h80, 1'b1);
        check_both("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0);
        step(8'h80, 1'b0);
        check_both("mid_after", 32'd7, 32'd7, 32'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
